// File: rtl/key_event_ctrl.sv
// Key gesture classifier (short / long / double click) driving a 4-mode LED sequencer with its own blink generator.
// Events are registered one cycle after the deciding edge, mode follows one cycle later, and led one cycle after that; there is no backpressure.
module key_event_ctrl #(
   parameter logic [19:0] LONG_CNT   = 20'd1000,
   parameter logic [19:0] DBL_GAP    = 20'd300,
   parameter logic [19:0] BLINK_HALF = 20'd50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_in,
   output logic       evt_short,
   output logic       evt_long,
   output logic       evt_double,
   output logic [1:0] mode,
   output logic       led
);

   localparam logic [19:0] LONG_LAST  = LONG_CNT - 20'd1;
   localparam logic [19:0] GAP_LAST   = DBL_GAP - 20'd1;
   localparam logic [19:0] BLINK_LAST = BLINK_HALF - 20'd1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS  = 3'd1,
      HELD   = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [19:0] cnt;
   logic        key_q;
   logic        key_press;
   logic        key_release;
   logic        hit_short;
   logic        hit_long;
   logic        hit_double;

   logic [1:0]  mode_nxt;
   logic        mode_chg;
   logic [19:0] blink_cnt;
   logic        fast_ph;
   logic        slow_ph;
   logic        slow_div;

   // key is active-low: a press is a 1->0 transition
   assign key_press   = key_q & ~key_in;
   assign key_release = ~key_q & key_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= 1'b1;
      end else begin
         key_q <= key_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // release beats the long-press threshold, and a second press beats the gap timeout
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (key_press) state_nxt = PRESS;
         end
         PRESS: begin
            if (key_release) begin
               state_nxt = WAIT2;
            end else if (cnt == LONG_LAST) begin
               state_nxt = HELD;
            end
         end
         HELD: begin
            if (key_release) state_nxt = IDLE;
         end
         WAIT2: begin
            if (key_press) begin
               state_nxt = PRESS2;
            end else if (cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end
         end
         PRESS2: begin
            if (key_release) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      hit_short  = 1'b0;
      hit_long   = 1'b0;
      hit_double = 1'b0;
      case (state)
         PRESS:   hit_long   = ~key_release & (cnt == LONG_LAST);
         WAIT2:   hit_short  = ~key_press & (cnt == GAP_LAST);
         PRESS2:  hit_double = key_release;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_short  <= 1'b0;
         evt_long   <= 1'b0;
         evt_double <= 1'b0;
      end else begin
         evt_short  <= hit_short;
         evt_long   <= hit_long;
         evt_double <= hit_double;
      end
   end

   // per-state dwell counter, restarted whenever the state changes
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 20'd0;
      end else if (state_nxt != state) begin
         cnt <= 20'd0;
      end else if (cnt != 20'hFFFFF) begin
         cnt <= cnt + 20'd1;
      end
   end

   always_comb begin
      mode_nxt = mode;
      if (evt_short) begin
         mode_nxt = mode + 2'd1;
      end else if (evt_long) begin
         mode_nxt = 2'd0;
      end else if (evt_double) begin
         mode_nxt = 2'd3;
      end
   end

   assign mode_chg = (mode_nxt != mode);

   always_ff @(posedge clk) begin
      if (rst) begin
         mode <= 2'd0;
      end else begin
         mode <= mode_nxt;
      end
   end

   // blink phases restart high on every real mode change so a new mode starts lit
   always_ff @(posedge clk) begin
      if (rst || mode_chg) begin
         blink_cnt <= 20'd0;
         fast_ph   <= 1'b1;
         slow_ph   <= 1'b1;
         slow_div  <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= 20'd0;
         fast_ph   <= ~fast_ph;
         slow_div  <= ~slow_div;
         if (slow_div) slow_ph <= ~slow_ph;
      end else begin
         blink_cnt <= blink_cnt + 20'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led <= 1'b0;
      end else begin
         case (mode)
            2'd0:    led <= 1'b0;
            2'd1:    led <= 1'b1;
            2'd2:    led <= slow_ph;
            default: led <= fast_ph;
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: gesture table with hand-computed event timing and mode, plus blink and mid-gesture reset sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_key_event_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_in;
   logic       evt_short;
   logic       evt_long;
   logic       evt_double;
   logic [1:0] mode;
   logic       led;

   int n_vec   = 0;
   int n_bad   = 0;
   int n_multi = 0;

   always #5 clk = ~clk;

   key_event_ctrl #(
      .LONG_CNT  (20'd20),
      .DBL_GAP   (20'd10),
      .BLINK_HALF(20'd4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .evt_short (evt_short),
      .evt_long  (evt_long),
      .evt_double(evt_double),
      .mode      (mode),
      .led       (led)
   );

   // kind: 1 short, 2 long, 3 double; first is the sample index of the first such pulse
   typedef struct {
      int h1;
      int gap;
      int h2;
      int kind;
      int first;
      int count;
      int mode;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   function automatic logic key_at(input int h1, input int gap, input int h2, input int k);
      key_at = !((k < h1) || (h2 > 0 && k >= h1 + gap && k < h1 + gap + h2));
   endfunction

   function automatic int evt_kind();
      evt_kind = evt_short ? 1 : (evt_long ? 2 : (evt_double ? 3 : 0));
   endfunction

   task automatic run_vec(input string tag, input vec_t v);
      int total;
      int first;
      int nexp;
      int nall;
      int kn;
      total = v.h1 + v.gap + v.h2 + 16;
      first = -1;
      nexp  = 0;
      nall  = 0;
      for (int k = 0; k <= total; k++) begin
         @(negedge clk);
         kn = evt_kind();
         if ($countones({evt_short, evt_long, evt_double}) > 1) n_multi++;
         if (kn != 0) nall++;
         if (kn != 0 && kn == v.kind) begin
            nexp++;
            if (first < 0) first = k;
         end
         if (k < total) key_in = key_at(v.h1, v.gap, v.h2, k);
      end
      check({tag, "_first"}, first, v.first);
      check({tag, "_count"}, nexp, v.count);
      check({tag, "_all_evts"}, nall, v.count);
      check({tag, "_mode"}, int'(mode), v.mode);
      if (v.mode <= 1) check({tag, "_led"}, int'(led), v.mode);
   endtask

   task automatic gesture_led(input string tag, input int h1, input int gap, input int h2,
                              input int first_k, input int period, input int total);
      for (int k = 0; k <= total; k++) begin
         @(negedge clk);
         if ($countones({evt_short, evt_long, evt_double}) > 1) n_multi++;
         if (k >= first_k)
            check($sformatf("%s_led_k%0d", tag, k), int'(led),
                  (((k - first_k) / period) % 2 == 0) ? 1 : 0);
         if (k < total) key_in = key_at(h1, gap, h2, k);
      end
   endtask

   initial begin
      vec_t tmp;
      int   n_dbl;
      int   n_sht;
      int   f_sht;

      //            h1  gap h2 kind first cnt mode
      vecs[0]  = '{ 5,  0,  0, 1,   16,   1,  1};
      vecs[1]  = '{ 5,  0,  0, 1,   16,   1,  2};
      vecs[2]  = '{ 5,  0,  0, 1,   16,   1,  3};
      vecs[3]  = '{ 5,  0,  0, 1,   16,   1,  0};
      vecs[4]  = '{ 5,  0,  0, 1,   16,   1,  1};
      vecs[5]  = '{30,  0,  0, 2,   21,   1,  0};
      vecs[6]  = '{ 3,  4,  3, 3,   11,   1,  3};
      vecs[7]  = '{ 3, 10,  2, 3,   16,   1,  3};
      vecs[8]  = '{20,  0,  0, 1,   31,   1,  0};
      vecs[9]  = '{21,  0,  0, 2,   21,   1,  0};
      vecs[10] = '{ 4, 11,  2, 1,   15,   2,  2};
      vecs[11] = '{ 2,  3, 40, 3,   46,   1,  3};
      vecs[12] = '{ 5,  0,  0, 1,   16,   1,  0};

      rst    = 1'b1;
      key_in = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_mode", int'(mode), 0);
      check("rst_led", int'(led), 0);
      check("rst_evts", int'({evt_short, evt_long, evt_double}), 0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // double from mode 0: fast blink, lit for 4 samples then dark for 4
      gesture_led("fast", 3, 4, 3, 13, 4, 28);
      check("fast_mode", int'(mode), 3);

      tmp = '{5, 0, 0, 1, 16, 1, 0};
      run_vec("c0", tmp);
      tmp = '{5, 0, 0, 1, 16, 1, 1};
      run_vec("c1", tmp);
      // short from mode 1: slow blink with an 8-cycle half period
      gesture_led("slow", 5, 0, 0, 18, 8, 33);
      check("slow_mode", int'(mode), 2);

      // reset lands while in PRESS2; key still low just after reset counts as a fresh press
      n_dbl = 0;
      n_sht = 0;
      f_sht = -1;
      for (int k = 0; k <= 26; k++) begin
         @(negedge clk);
         if (evt_double) n_dbl++;
         if (evt_short) begin
            n_sht++;
            if (f_sht < 0) f_sht = k;
         end
         if (k == 9) check("mrst_mode_before", int'(mode), 2);
         if (k == 10) begin
            check("mrst_mode_after", int'(mode), 0);
            check("mrst_led_after", int'(led), 0);
            check("mrst_evts_after", int'({evt_short, evt_long, evt_double}), 0);
         end
         if (k < 26) begin
            rst    = (k == 9);
            key_in = key_at(3, 4, 5, k);
         end
      end
      check("mrst_no_double", n_dbl, 0);
      check("mrst_short_count", n_sht, 1);
      check("mrst_short_first", f_sht, 23);
      check("mrst_mode_end", int'(mode), 1);

      check("evt_one_hot", n_multi, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
